pipe_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core. Sits beside the id/exe stages and drives the per-stage stall and flush controls. It detects load-use hazards that id's forwarding network cannot resolve, and sequences the multi-cycle M-extension divider with a start/done handshake. It also flushes wrong-path instructions on a taken jump/branch resolved in exe.

---
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bundle: id/exe hazard inputs and divider handshake from the pipeline,
// per-stage stall/flush controls and divider start/abort back to it.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif

interface pipe_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                    id_reg1_re_i;
    logic [`RADDR_WIDTH-1:0] id_reg1_raddr_i;
    logic                    id_reg2_re_i;
    logic [`RADDR_WIDTH-1:0] id_reg2_raddr_i;
    logic                    exe_is_load_i;
    logic                    exe_reg_we_i;
    logic [`RADDR_WIDTH-1:0] exe_reg_waddr_i;
    logic                    exe_jump_i;
    logic                    div_req_i;
    logic                    div_done_i;

    logic [4:0]              stall_o;
    logic                    flush_if_id_o;
    logic                    flush_id_exe_o;
    logic                    div_start_o;
    logic                    div_abort_o;
    logic [CNT_WIDTH-1:0]    stall_cnt_o;

    // Pipeline side: presents hazard/divider status, obeys the controls.
    modport master (
        output id_reg1_re_i, id_reg1_raddr_i, id_reg2_re_i, id_reg2_raddr_i,
        output exe_is_load_i, exe_reg_we_i, exe_reg_waddr_i, exe_jump_i,
        output div_req_i, div_done_i,
        input  stall_o, flush_if_id_o, flush_id_exe_o, div_start_o, div_abort_o, stall_cnt_o
    );

    modport slave (
        input  id_reg1_re_i, id_reg1_raddr_i, id_reg2_re_i, id_reg2_raddr_i,
        input  exe_is_load_i, exe_reg_we_i, exe_reg_waddr_i, exe_jump_i,
        input  div_req_i, div_done_i,
        output stall_o, flush_if_id_o, flush_id_exe_o, div_start_o, div_abort_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for load-use, multi-cycle divide and exe-resolved jumps; controls are
// combinational (0 cycles), only the stall counter is registered. Optional divider timeout: DIV_TIMEOUT_EN.
module pipe_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    pipe_ctrl_if.slave  ctl
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    div_state_e           state;
    div_state_e           state_nxt;
    logic                 rs1_hit;
    logic                 rs2_hit;
    logic                 lu;
    logic                 div_stall;
    logic                 timeout;
    logic                 abort_q;
    logic [4:0]           stall;
    logic                 flush_if_id;
    logic                 flush_id_exe;
    logic                 div_start;
    logic                 div_abort;
    logic [CNT_WIDTH-1:0] stall_cnt;

    if (DIV_TIMEOUT < 1) begin : g_bad_timeout
        $error("pipe_ctrl: DIV_TIMEOUT must be at least 1");
    end

    // x0 never carries a real dependency, so a load targeting it cannot create a hazard.
    assign rs1_hit = ctl.id_reg1_re_i && (ctl.id_reg1_raddr_i == ctl.exe_reg_waddr_i);
    assign rs2_hit = ctl.id_reg2_re_i && (ctl.id_reg2_raddr_i == ctl.exe_reg_waddr_i);
    assign lu      = ctl.exe_is_load_i && ctl.exe_reg_we_i && (|ctl.exe_reg_waddr_i)
                     && (rs1_hit || rs2_hit);

    assign div_stall = ((state == IDLE) && ctl.div_req_i) || (state == BUSY);

`ifdef DIV_TIMEOUT_EN
    localparam int TW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;

    logic [TW-1:0] busy_cnt;

    // Counter sits at zero outside BUSY, so the first BUSY cycle always sees 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cnt <= '0;
        end else if (state != BUSY) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    assign timeout = (state == BUSY) && (busy_cnt == TW'(DIV_TIMEOUT - 1));

    // A done arriving with the timeout is a real result, so it cancels the abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= timeout && !ctl.div_done_i;
        end
    end
`else
    assign timeout = 1'b0;
    assign abort_q = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ctl.div_req_i) state_nxt = BUSY;
            BUSY:    if (ctl.div_done_i || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divider stall outranks a jump (exe is frozen, so the jump is not yet final) and a
    // jump outranks load-use (the dependent instruction is wrong-path anyway).
    always_comb begin
        stall        = 5'b00000;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        if (!rst_i) begin
            div_start = (state == IDLE) && ctl.div_req_i;
            div_abort = (state == DONE) && abort_q;
            if (div_stall) begin
                stall = 5'b01111;
            end else if (ctl.exe_jump_i) begin
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
            end else if (lu) begin
                stall        = 5'b00111;
                flush_id_exe = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (|stall) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ctl.stall_o        = stall;
    assign ctl.flush_if_id_o  = flush_if_id;
    assign ctl.flush_id_exe_o = flush_id_exe;
    assign ctl.div_start_o    = div_start;
    assign ctl.div_abort_o    = div_abort;
    assign ctl.stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed test-plan steps followed by random traffic, all checked against a cycle model of the rules.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif

module tb_pipe_ctrl;

    localparam int AW   = `RADDR_WIDTH;
    localparam int TOUT = 8;
`ifdef DIV_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic          rst;
        logic          r1e;
        logic [AW-1:0] r1a;
        logic          r2e;
        logic [AW-1:0] r2a;
        logic          ld;
        logic          we;
        logic [AW-1:0] wa;
        logic          jmp;
        logic          req;
        logic          done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    pipe_ctrl_if #(.CNT_WIDTH(32)) bus ();

    pipe_ctrl #(.DIV_TIMEOUT(TOUT), .CNT_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: divide phase, BUSY cycles elapsed, pending abort, stall-cycle total.
    int          m_phase = 0;
    int          m_busy  = 0;
    bit          m_abort = 1'b0;
    logic [31:0] m_cnt   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input vec_t v);
        bit         ds;
        bit         hz;
        bit         jp;
        logic [4:0] e_stall;
        bit         e_fi;
        bit         e_fe;
        bit         e_st;
        bit         e_ab;

        @(negedge clk);
        rst                 = v.rst;
        bus.id_reg1_re_i    = v.r1e;
        bus.id_reg1_raddr_i = v.r1a;
        bus.id_reg2_re_i    = v.r2e;
        bus.id_reg2_raddr_i = v.r2a;
        bus.exe_is_load_i   = v.ld;
        bus.exe_reg_we_i    = v.we;
        bus.exe_reg_waddr_i = v.wa;
        bus.exe_jump_i      = v.jmp;
        bus.div_req_i       = v.req;
        bus.div_done_i      = v.done;
        #1;

        e_stall = 5'b00000;
        e_fi    = 1'b0;
        e_fe    = 1'b0;
        e_st    = 1'b0;
        e_ab    = 1'b0;
        if (!v.rst) begin
            ds = (m_phase == 0 && v.req) || m_phase == 1;
            hz = v.ld && v.we && v.wa != 0
                 && ((v.r1e && v.r1a == v.wa) || (v.r2e && v.r2a == v.wa));
            jp = v.jmp && !ds;
            if (ds)      e_stall = 5'b01111;
            else if (jp) e_stall = 5'b00000;
            else if (hz) e_stall = 5'b00111;
            e_fi = jp;
            e_fe = jp || (hz && !ds);
            e_st = (m_phase == 0) && v.req;
            e_ab = (m_phase == 2) && m_abort;
        end

        chk("stall_o",        32'(bus.stall_o),        32'(e_stall));
        chk("flush_if_id_o",  32'(bus.flush_if_id_o),  32'(e_fi));
        chk("flush_id_exe_o", 32'(bus.flush_id_exe_o), 32'(e_fe));
        chk("div_start_o",    32'(bus.div_start_o),    32'(e_st));
        chk("div_abort_o",    32'(bus.div_abort_o),    32'(e_ab));
        chk("stall_cnt_o",    bus.stall_cnt_o,         m_cnt);

        if (v.rst) begin
            m_phase = 0;
            m_busy  = 0;
            m_abort = 1'b0;
            m_cnt   = '0;
        end else begin
            if (e_stall != 0) m_cnt = m_cnt + 1;
            case (m_phase)
                0: if (v.req) begin m_phase = 1; m_busy = 0; end
                1: begin
                    m_busy++;
                    if (v.done) begin
                        m_phase = 2;
                        m_abort = 1'b0;
                    end else if (TIMEOUT_ON && m_busy == TOUT) begin
                        m_phase = 2;
                        m_abort = 1'b1;
                    end
                end
                default: begin m_phase = 0; m_abort = 1'b0; end
            endcase
        end
    endtask

    initial begin
        vec_t        v;
        logic [31:0] c0;

        rst = 1'b1;
        v   = '0;

        // Reset
        v.rst = 1'b1;
        cycle(v);
        cycle(v);
        v.rst = 1'b0;
        cycle(v);
        chk("reset_cnt", bus.stall_cnt_o, 32'd0);

        // lw x5 in exe, add x6,x5,x7 in id
        v = '0; v.ld = 1; v.we = 1; v.wa = 5; v.r1e = 1; v.r1a = 5; v.r2e = 1; v.r2a = 7;
        cycle(v);
        chk("lu_stall", 32'(bus.stall_o), 32'(5'b00111));
        v = '0;
        cycle(v);
        chk("lu_clear", 32'(bus.stall_o), 32'd0);

        // Load to x0, id reads x0
        v = '0; v.ld = 1; v.we = 1; v.wa = 0; v.r1e = 1; v.r1a = 0;
        cycle(v);

        // Divide, done after 3 BUSY cycles, done pulse in IDLE ignored first
        v = '0; v.done = 1;
        cycle(v);
        v = '0; v.req = 1;
        cycle(v);
        c0 = bus.stall_cnt_o;
        cycle(v);
        cycle(v);
        v.done = 1;
        cycle(v);
        v = '0;
        cycle(v);
        chk("div_cnt_delta", bus.stall_cnt_o - c0, 32'd4);

        // Back-to-back divide with jump pending throughout BUSY, flushing in DONE
        v = '0; v.req = 1; v.jmp = 1;
        cycle(v);
        cycle(v);
        cycle(v);
        v.done = 1;
        cycle(v);
        v.done = 0;
        cycle(v);
        chk("jump_in_done", 32'(bus.flush_if_id_o), 32'd1);
        v = '0; v.req = 1;
        cycle(v);
        v = '0; v.done = 1;
        cycle(v);
        v = '0;
        cycle(v);

        // Jump together with a load-use condition
        v = '0; v.jmp = 1; v.ld = 1; v.we = 1; v.wa = 9; v.r2e = 1; v.r2a = 9;
        cycle(v);

        // Reset in the middle of BUSY
        v = '0; v.req = 1;
        cycle(v);
        v.req = 0;
        cycle(v);
        cycle(v);
        v.rst = 1;
        cycle(v);
        v = '0;
        cycle(v);
        chk("rst_busy_cnt", bus.stall_cnt_o, 32'd0);

        // No done: default build waits, timeout build aborts after TOUT BUSY cycles
        v = '0; v.req = 1;
        cycle(v);
        v.req = 0;
        for (int i = 0; i < TOUT + 2; i++) cycle(v);
        v.done = 1;
        cycle(v);
        v = '0;
        cycle(v);

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 600; i++) begin
            v      = '0;
            v.rst  = ($urandom_range(0, 63) == 0);
            v.r1e  = $urandom_range(0, 1);
            v.r1a  = AW'($urandom_range(0, 3));
            v.r2e  = $urandom_range(0, 1);
            v.r2a  = AW'($urandom_range(0, 3));
            v.ld   = $urandom_range(0, 1);
            v.we   = ($urandom_range(0, 3) != 0);
            v.wa   = AW'($urandom_range(0, 3));
            v.jmp  = ($urandom_range(0, 5) == 0);
            v.req  = ($urandom_range(0, 2) == 0);
            v.done = ($urandom_range(0, 3) == 0);
            cycle(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
